// File: rtl/uart_byte_tx_pkg.sv
// Shared UART definitions: line-state encoding, default clocking and the bit-period derivation,
// kept here so a future receiver can reuse them.
package uart_byte_tx_pkg;

   localparam int DEF_CLK_FREQ_HZ = 50_000_000;
   localparam int DEF_BAUD        = 115200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Integer division; the truncation error is the caller's baud tolerance budget.
   function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
      return clk_freq_hz / baud;
   endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte request / busy handshake between the packet sender (master) and the UART transmitter (slave).
interface uart_byte_tx_if;

   logic       transmit;
   logic [7:0] tx_byte;
   logic       is_transmitting;
   logic       tx_overrun;

   modport master (
      output transmit,
      output tx_byte,
      input  is_transmitting,
      input  tx_overrun
   );

   modport slave (
      input  transmit,
      input  tx_byte,
      output is_transmitting,
      output tx_overrun
   );

endinterface

// File: rtl/uart_byte_tx_baud_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the terminal count.
// clear restarts the count so the next period is full width; no backpressure.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_tick
);

   localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] baud_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
      end else if (clear || (baud_cnt == CNT_MAX)) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CW'(1);
      end
   end

   assign bit_tick = !clear && (baud_cnt == CNT_MAX);

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: request to busy/start bit in 1 cycle, frame (9+STOP_BITS)*CLKS_PER_BIT cycles.
// Busy back-pressures the sender; requests seen while busy are dropped and flagged in sticky tx_overrun.
module uart_byte_tx
   import uart_byte_tx_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
   parameter int BAUD         = DEF_BAUD,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD),
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_byte_tx_if.slave    bus,
   output logic             tx
);

   localparam logic [2:0] LAST_DATA_BIT = 3'd7;
   localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

   tx_state_t  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       ovr_q, ovr_d;
   logic       clear;
   logic       bit_tick;

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      ovr_d     = ovr_q;
      clear     = 1'b0;

      if (bus.transmit && (busy_q || (state_q != IDLE))) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.transmit) begin
               shift_d   = bus.tx_byte;
               bit_cnt_d = '0;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               clear     = 1'b1;
               state_d   = START;
            end
         end
         START: begin
            if (bit_tick) begin
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_cnt_q == LAST_DATA_BIT) begin
                  tx_d      = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = STOP;
               end else begin
                  // Present the next bit in the same edge that retires the current one.
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (bit_cnt_q == LAST_STOP_BIT) begin
                  busy_d    = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign tx                  = tx_q;
   assign bus.is_transmitting = busy_q;
   assign bus.tx_overrun      = ovr_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx with CLKS_PER_BIT=4: per-cycle reference model of the line, a mid-bit
// decoder of the serial output, a vector table, directed corner cases and a randomized phase.
module tb_uart_byte_tx;

   localparam int CPB   = 4;
   localparam int SB    = 1;
   localparam int FRAME = (9 + SB) * CPB;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic tx;

   uart_byte_tx_if bus ();

   uart_byte_tx #(
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (SB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a frame is (start, data LSB first, stop) with each bit CPB cycles long.
   int         cyc     = 0;
   int         m_start = -1000;
   int         m_end   = -1000;
   logic [7:0] m_byte  = '0;
   logic       m_ovr   = 1'b0;
   logic [7:0] exp_q[$];

   // Line decoder state
   logic       prev_busy = 1'b0;
   bit         dec_act   = 1'b0;
   int         dec_s     = 0;
   logic [7:0] dec_v     = '0;
   logic [7:0] rx_q[$];
   int         starts[$];

   function automatic bit m_busy(input int c);
      return (c >= m_start) && (c < m_end);
   endfunction

   function automatic logic m_tx(input int c);
      int idx;
      if (!m_busy(c)) return 1'b1;
      idx = (c - m_start) / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_byte[idx-1];
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs for this cycle, advance, then compare the new outputs to the model.
   task automatic cycle(input logic t, input logic [7:0] b);
      int off;
      int i;
      bus.transmit = t;
      bus.tx_byte  = b;
      if (t) begin
         if (m_busy(cyc)) begin
            m_ovr = 1'b1;
         end else begin
            m_start = cyc + 1;
            m_end   = cyc + 1 + FRAME;
            m_byte  = b;
            exp_q.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("line_tx", tx, m_tx(cyc));
      chk("line_busy", bus.is_transmitting, m_busy(cyc));
      chk("line_overrun", bus.tx_overrun, m_ovr);

      if (!dec_act && bus.is_transmitting && !prev_busy) begin
         dec_act = 1'b1;
         dec_s   = cyc;
         dec_v   = '0;
         starts.push_back(cyc);
      end
      if (dec_act) begin
         off = cyc - dec_s;
         if (off % CPB == CPB / 2) begin
            i = off / CPB;
            if (i == 0) begin
               chk("start_bit", tx, 1'b0);
            end else if (i <= 8) begin
               dec_v[i-1] = tx;
            end else begin
               chk("stop_bit", tx, 1'b1);
               rx_q.push_back(dec_v);
               dec_act = 1'b0;
            end
         end
      end
      prev_busy = bus.is_transmitting;
   endtask

   task automatic apply_reset();
      bus.transmit = 1'b0;
      bus.tx_byte  = '0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", bus.is_transmitting, 1'b0);
      chk("rst_overrun", bus.tx_overrun, 1'b0);
      m_start   = -1000;
      m_end     = -1000;
      m_ovr     = 1'b0;
      exp_q.delete();
      rx_q.delete();
      starts.delete();
      dec_act   = 1'b0;
      prev_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.is_transmitting && n < 200) begin
         cycle(1'b0, 8'h00);
         n++;
      end
      if (n >= 200) chk("idle_timeout", 1, 0);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 8'h00);
   endtask

   typedef struct {
      logic [7:0] b;
      int         gap;
      int         hold;
      logic       exp_ovr;
   } vec_t;

   initial begin
      vec_t       vt[6];
      logic [9:0] a5_bits;
      logic [7:0] pkt[14];
      int         t0;
      int         s;
      int         nstart;

      bus.transmit = 1'b0;
      bus.tx_byte  = '0;

      // Reset and idle line
      apply_reset();
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, 8'h00);
         chk("idle_tx_high", tx, 1'b1);
      end

      // Single byte 0xA5, line pattern written out by hand
      a5_bits = 10'b1101001010;
      cycle(1'b1, 8'hA5);
      chk("a5_busy_next_edge", bus.is_transmitting, 1'b1);
      t0 = cyc;
      for (int k = 0; k < FRAME; k++) begin
         chk("a5_bit", tx, a5_bits[k / CPB]);
         chk("a5_busy_hold", bus.is_transmitting, 1'b1);
         cycle(1'b0, 8'h00);
      end
      chk("a5_frame_len", cyc - t0, FRAME);
      chk("a5_busy_low", bus.is_transmitting, 1'b0);
      chk("a5_decoded", rx_q[rx_q.size()-1], 8'hA5);

      // Vector table: byte, idle gap after busy falls, request length, sticky overrun afterwards
      vt[0] = '{8'h55, 0, 1, 1'b0};
      vt[1] = '{8'hAA, 0, 1, 1'b0};
      vt[2] = '{8'h00, 3, 1, 1'b0};
      vt[3] = '{8'hFF, 1, 1, 1'b0};
      vt[4] = '{8'h81, 0, 1, 1'b0};
      vt[5] = '{8'h3C, 2, 3, 1'b1};
      for (int v = 0; v < 6; v++) begin
         wait_idle();
         nstart = starts.size();
         drain(vt[v].gap);
         for (int h = 0; h < vt[v].hold; h++) cycle(1'b1, vt[v].b);
         s = cyc - vt[v].hold + 1;
         while (cyc < s + FRAME - 2) cycle(1'b0, 8'h00);
         chk("vec_decoded", rx_q[rx_q.size()-1], vt[v].b);
         chk("vec_overrun", bus.tx_overrun, vt[v].exp_ovr);
         if (v > 0 && starts.size() > nstart)
            chk("vec_start_spacing", starts[nstart] - starts[nstart-1], FRAME + 1 + vt[v].gap);
      end
      drain(10);

      // Overrun: second request 10 cycles into a frame is dropped
      apply_reset();
      drain(3);
      cycle(1'b1, 8'h12);
      drain(9);
      cycle(1'b1, 8'hFF);
      chk("ovr_set", bus.tx_overrun, 1'b1);
      drain(FRAME + 10);
      chk("ovr_one_frame", rx_q.size(), 1);
      chk("ovr_byte", rx_q[0], 8'h12);
      drain(50);
      chk("ovr_sticky", bus.tx_overrun, 1'b1);

      // Reset during DATA bit 3, then a clean frame
      apply_reset();
      drain(2);
      cycle(1'b1, 8'h3C);
      s = cyc;
      while (cyc < s + 4 * CPB + 1) cycle(1'b0, 8'h00);
      chk("mid_in_frame", bus.is_transmitting, 1'b1);
      apply_reset();
      drain(2);
      cycle(1'b1, 8'h0F);
      drain(FRAME + 4);
      chk("mid_resume_count", rx_q.size(), 1);
      chk("mid_resume_byte", rx_q[0], 8'h0F);

      // Packet sender emulation: waits for idle, pulses, re-checks busy two edges later
      apply_reset();
      pkt[0]  = 8'h55;
      pkt[13] = 8'hAA;
      for (int k = 1; k < 13; k++) pkt[k] = 8'($urandom);
      for (int k = 0; k < 14; k++) begin
         wait_idle();
         drain($urandom_range(0, 3));
         cycle(1'b1, pkt[k]);
         cycle(1'b0, 8'h00);
         chk("pkt_busy_recheck", bus.is_transmitting, 1'b1);
      end
      drain(FRAME + 4);
      chk("pkt_len", rx_q.size(), 14);
      for (int k = 0; k < 14 && k < rx_q.size(); k++) chk("pkt_byte", rx_q[k], pkt[k]);
      chk("pkt_no_overrun", bus.tx_overrun, 1'b0);

      // Random requests regardless of busy, checked cycle by cycle against the model
      apply_reset();
      for (int k = 0; k < 1500; k++) cycle($urandom_range(0, 7) == 0, 8'($urandom));
      drain(FRAME + 4);
      chk("rand_count", rx_q.size(), exp_q.size());
      for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
         chk("rand_byte", rx_q[k], exp_q[k]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
